// File: rtl/vec_dmem_pkg.sv
// Shared types and default geometry for the vector data-memory controller.
package vec_dmem_pkg;

  localparam int NLANES_DEF = 4;
  localparam int WIDTH_DEF  = 32;
  localparam int NBANKS_DEF = 4;
  localparam int DEPTH_DEF  = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index width that never collapses to zero bits for a count of one.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port memory bank: one read or one write per cycle, registered read.
// Contents are deliberately not reset; rdata holds its last read value.
module dmem_bank
  import vec_dmem_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ROWS  = DEPTH_DEF / NBANKS_DEF,
  parameter int RW    = clog2_min1(ROWS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [RW-1:0]    row,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ROWS];

  // Write updates the array; read registers the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[row] <= wdata;
      else    rdata    <= mem[row];
    end
  end

endmodule

// File: rtl/vec_dmem_ctrl.sv
// Vector data-memory controller: scatters up to NLANES word accesses across
// NBANKS single-port banks, one lane per bank per cycle, lowest lane first.
// Read data comes back one cycle after the bank access, so the last reads
// of a request are forwarded straight from the bank outputs during the
// first RESP cycle while they are being captured into the lane registers.
module vec_dmem_ctrl
  import vec_dmem_pkg::*;
#(
  parameter int NLANES = NLANES_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NBANKS = NBANKS_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_vec,
  input  logic                          req_we,
  input  logic [NLANES-1:0]             req_mask,
  input  logic [NLANES-1:0][WIDTH-1:0]  req_addr,
  input  logic [NLANES-1:0][WIDTH-1:0]  req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [NLANES-1:0][WIDTH-1:0]  resp_rdata,
  output logic [NLANES-1:0]             resp_err
);

  localparam int LW     = clog2_min1(NLANES);
  localparam int LOG_NB = $clog2(NBANKS);
  localparam int BW     = clog2_min1(NBANKS);
  localparam int ROWS   = DEPTH / NBANKS;
  localparam int RW     = clog2_min1(ROWS);

  state_t state, state_nx;

  logic                         we_r;
  logic [NLANES-1:0][WIDTH-1:0] addr_r, wdata_r, rdata_r;
  logic [NLANES-1:0]            pend, err_r, served, bad;
  logic [NLANES-1:0]            eff_mask;
  logic                         accept, busy;

  logic [NLANES-1:0][BW-1:0]    bank_of;
  logic [NLANES-1:0][RW-1:0]    row_of;

  logic [NBANKS-1:0]            sel_vld, bank_en, cap_vld;
  logic [NBANKS-1:0][LW-1:0]    sel_lane, cap_lane;
  logic [NBANKS-1:0][RW-1:0]    bank_row;
  logic [NBANKS-1:0][WIDTH-1:0] bank_wd, bank_q;

  assign eff_mask = req_vec ? req_mask : NLANES'(1);
  assign accept   = (state == IDLE) && req_valid;
  assign busy     = (state == BUSY);

  // Per-lane address decode: word index split into bank and row, plus error.
  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    logic [WIDTH-3:0] word;
    assign word   = addr_r[l][WIDTH-1:2];
    assign bad[l] = (addr_r[l][1:0] != 2'b00) || ({2'b00, word} >= WIDTH'(DEPTH));
    if (LOG_NB == 0) begin : g_nb1
      assign bank_of[l] = '0;
    end else begin : g_nbn
      assign bank_of[l] = word[BW-1:0];
    end
    assign row_of[l] = word[LOG_NB +: RW];
  end

  // Per-bank priority encoder: lowest pending lane mapped to each bank.
  always_comb begin
    served = '0;
    for (int b = 0; b < NBANKS; b++) begin
      sel_vld[b]  = 1'b0;
      sel_lane[b] = '0;
      for (int l = NLANES - 1; l >= 0; l--) begin
        if (pend[l] && (bank_of[l] == BW'(b))) begin
          sel_vld[b]  = 1'b1;
          sel_lane[b] = LW'(l);
        end
      end
      if (busy && sel_vld[b]) served[sel_lane[b]] = 1'b1;
    end
  end

  // Bank port drive; error lanes take the slot but never touch the array.
  always_comb begin
    for (int b = 0; b < NBANKS; b++) begin
      bank_en[b]  = busy && sel_vld[b] && !bad[sel_lane[b]];
      bank_row[b] = row_of[sel_lane[b]];
      bank_wd[b]  = wdata_r[sel_lane[b]];
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    dmem_bank #(.WIDTH(WIDTH), .ROWS(ROWS), .RW(RW)) u_bank (
      .clk   (clk),
      .en    (bank_en[b]),
      .we    (we_r),
      .row   (bank_row[b]),
      .wdata (bank_wd[b]),
      .rdata (bank_q[b])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: empty mask skips BUSY; BUSY ends when the last lane is served.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) state_nx = (eff_mask != '0) ? BUSY : RESP;
      BUSY: if ((pend & ~served) == '0) state_nx = RESP;
      RESP: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  // Request latch and pending-lane bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      pend    <= '0;
    end else if (accept) begin
      we_r    <= req_we;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      pend    <= eff_mask;
    end else if (busy) begin
      pend    <= pend & ~served;
    end
  end

  // Result capture: read data lands one cycle after its bank access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r  <= '0;
      err_r    <= '0;
      cap_vld  <= '0;
      cap_lane <= '0;
    end else begin
      for (int b = 0; b < NBANKS; b++) begin
        cap_vld[b]  <= busy && sel_vld[b] && !we_r && !bad[sel_lane[b]];
        cap_lane[b] <= sel_lane[b];
      end
      if (accept) begin
        rdata_r <= '0;
        err_r   <= '0;
      end else begin
        for (int b = 0; b < NBANKS; b++) begin
          if (cap_vld[b]) rdata_r[cap_lane[b]] <= bank_q[b];
          if (busy && sel_vld[b]) err_r[sel_lane[b]] <= bad[sel_lane[b]];
        end
      end
    end
  end

  // Response data with forwarding of reads still in flight from the banks.
  always_comb begin
    resp_rdata = rdata_r;
    for (int b = 0; b < NBANKS; b++) begin
      if (cap_vld[b]) resp_rdata[cap_lane[b]] = bank_q[b];
    end
  end

  assign resp_err = err_r;

endmodule

// File: doc/vec_dmem_ctrl.md
VEC_DMEM_CTRL -- requirements
Module: vec_dmem_ctrl

Interface
REQ-001 Parameter NLANES, default 4: vector lane count, power of two, 1..16.
REQ-002 Parameter WIDTH, default 32: data and address width in bits.
REQ-003 Parameter NBANKS, default 4: single-port memory banks, power of two, at least 1.
REQ-004 Parameter DEPTH, default 256: total words across all banks, a multiple of NBANKS.
REQ-005 Port clk  in  1: single clock, rising edge.
REQ-006 Port reset  in  1: asynchronous, active-high reset.
REQ-007 Port req_valid  in  1: request offered.
REQ-008 Port req_ready  out  1: controller accepts a request this cycle.
REQ-009 Port req_vec  in  1: 1 means a vector request using req_mask; 0 means a scalar request on lane 0 only.
REQ-010 Port req_we  in  1: write when 1, read when 0.
REQ-011 Port req_mask  in  NLANES: active lanes; ignored when req_vec=0.
REQ-012 Port req_addr  in  NLANES x WIDTH: per-lane byte address.
REQ-013 Port req_wdata  in  NLANES x WIDTH: per-lane write data.
REQ-014 Port resp_valid  out  1: response available.
REQ-015 Port resp_ready  in  1: consumer takes the response.
REQ-016 Port resp_rdata  out  NLANES x WIDTH: per-lane read data.
REQ-017 Port resp_err  out  NLANES: per-lane misaligned-address or out-of-range flag.

Function
REQ-018 Word index = addr>>2; bank = word index mod NBANKS; row = word index / NBANKS.
REQ-019 States: IDLE, BUSY, RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-020 IDLE: on req_valid=1, latch we, addresses, wdata and effective mask; the effective mask is req_mask for vectors and 1 (lane 0) for scalars.
REQ-021 IDLE to BUSY when the effective mask is nonzero; IDLE to RESP when it is zero, with no memory access and rdata/err all 0.
REQ-022 BUSY, each cycle, per bank: serve the lowest-index pending lane mapped to that bank, then clear its pending bit.
REQ-023 Serving a read captures the bank word into that lane's rdata register; serving a write updates the bank word.
REQ-024 Lanes that are not active return rdata=0 and err=0.
REQ-025 BUSY to RESP in the cycle the last pending bit clears; the response therefore appears at accept+1+(maximum number of lanes mapped to a single bank).
REQ-026 Conflict-free request: accept at cycle N, serve at N+1, resp_valid at N+2.
REQ-027 Same-address lanes within one request are served in ascending lane order: the highest-index write wins, and a read sees all lower-lane writes.
REQ-028 A lane is in error when addr[1:0] != 0 or word index >= DEPTH; err is set for that lane, no access is made, rdata=0, and the lane still consumes one serve slot.
REQ-029 RESP holds resp_valid, rdata and err stable until resp_ready=1; on that cycle the block returns to IDLE, with req_ready=1 the next cycle.
REQ-030 resp_ready is ignored outside RESP; req_valid is ignored outside IDLE.

Reset
REQ-031 Asynchronous reset forces IDLE, clears the pending mask, and sets req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-032 Memory contents are not reset; reset during BUSY abandons remaining lanes, and writes already served persist.

Structure
REQ-033 Package vec_dmem_pkg holds the state enum and the default NLANES/WIDTH/NBANKS/DEPTH constants.
REQ-034 One sub-module, dmem_bank: a synchronous single-port bank of DEPTH/NBANKS words with a registered read and no reset, instantiated NBANKS times.
REQ-035 Per-bank lowest-index lane selection is a combinational priority encoder inside vec_dmem_ctrl.

Verification
REQ-036 Scalar write 0xDEADBEEF to address 0x10, then scalar read of 0x10 -> rdata[0]=0xDEADBEEF, err=0, resp_valid two cycles after accept.
REQ-037 Vector write, mask 1111, addresses 0x0/0x4/0x8/0xC (four distinct banks) -> one BUSY cycle; a follow-up vector read returns the four written values.
REQ-038 Vector read, mask 1111, addresses 0x0/0x10/0x20/0x30 (all bank 0) -> four BUSY cycles, resp_valid at accept+5, correct data in each lane.
REQ-039 Vector write, all lanes to 0x40, data 1/2/3/4 -> a later read of 0x40 returns 4; lane 1 with address 0x41 or 0x400 (DEPTH=256) -> err[1]=1 and memory unchanged.
REQ-040 Hold resp_ready=0 for 5 cycles -> response stable and req_ready=0; mask 0000 -> RESP at accept+1; reset asserted in BUSY -> IDLE immediately with outputs cleared.
